pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush control for a 5-stage pipeline with an EX/MEM write scoreboard and no forwarding.
// Latency: enables, flush and bubble are combinational in the same cycle; state and counters update on the falling edge.
// Backpressure: mem_busy freezes every stage; an RS/RT hazard holds PC and IF_ID while a bubble enters ID_EX.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_adr,
    input  logic [REG_AW-1:0] id_rt_adr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_regWrite,
    input  logic [REG_AW-1:0] id_wrAdr,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_MEMW  = 2'd3
    } state_t;

    localparam int                BUSY_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [BUSY_W-1:0] BUSY_MAX  = BUSY_W'(MEM_TIMEOUT);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MEM_TIMEOUT - 1);

    logic              ex_vld;
    logic [REG_AW-1:0] ex_adr;
    logic              mem_vld;
    logic [REG_AW-1:0] mem_adr;
    logic [BUSY_W-1:0] busy_cnt;
    state_t            state_q;
    state_t            act;
    logic              rs_hit;
    logic              rt_hit;
    logic              hazard;

    // WB is deliberately absent: the register file writes before it reads.
    assign rs_hit = (ex_vld  && (ex_adr  == id_rs_adr)) ||
                    (mem_vld && (mem_adr == id_rs_adr));
    assign rt_hit = (ex_vld  && (ex_adr  == id_rt_adr)) ||
                    (mem_vld && (mem_adr == id_rt_adr));
    assign hazard = id_valid && ((id_uses_rs && rs_hit) || (id_uses_rt && rt_hit));

    always_comb begin
        act = ST_RUN;
        if (rst)
            act = ST_RUN;
        else if (mem_busy)
            act = ST_MEMW;
        else if (ex_redirect)
            act = ST_FLUSH;
        else if (hazard)
            act = ST_HAZ;
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        case (act)
            ST_MEMW: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
            end
            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ST_HAZ: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

    // Same falling edge as the pipeline buffers, so the scoreboard tracks EX/MEM exactly.
    always_ff @(negedge clk) begin
        if (rst) begin
            ex_vld    <= 1'b0;
            ex_adr    <= '0;
            mem_vld   <= 1'b0;
            mem_adr   <= '0;
            state_q   <= ST_RUN;
            stall_cnt <= '0;
            busy_cnt  <= '0;
            mem_err   <= 1'b0;
        end else begin
            state_q <= act;
            case (act)
                ST_MEMW: ;
                ST_RUN: begin
                    mem_vld <= ex_vld;
                    mem_adr <= ex_adr;
                    ex_vld  <= id_valid && id_regWrite;
                    ex_adr  <= id_wrAdr;
                end
                default: begin
                    mem_vld <= ex_vld;
                    mem_adr <= ex_adr;
                    ex_vld  <= 1'b0;
                end
            endcase

            if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (act == ST_MEMW) begin
                if (busy_cnt != BUSY_MAX)
                    busy_cnt <= busy_cnt + BUSY_W'(1);
                if (busy_cnt >= BUSY_LAST)
                    mem_err <= 1'b1;
            end else begin
                busy_cnt <= '0;
            end
        end
    end

endmodule
